parallax_starfield: RTL

PARALLAX_STARFIELD -- requirements
Module: parallax_starfield

---
 rtl/parallax_starfield.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/parallax_starfield.sv
// parallax_starfield: multi-layer LFSR starfield with per-layer scroll speed.
// Each layer reseeds its LFSR once per (stretchable) frame; lowest layer wins.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   en            pixel enable; all layer state advances only on en
//   data_in       speed value for the layer selected by addr
//   addr, write   speed write strobe; addr >= LAYERS is ignored
//   sf_on         a star is present at this pixel
//   sf_star       brightness of the winning star
//   sf_layer      index of the winning layer
//
// Optional build macro: PARALLAX_TWINKLE_EN adds a frame counter that
// halves a winning star's brightness when its sreg[8] matches frame[3].

module parallax_starfield #(
  parameter int             H      = 800,
  parameter int             V      = 525,
  parameter int             LAYERS = 3,
  parameter int             LEN    = 25,
  parameter logic [LEN-1:0] TAPS   = 25'h1400000,
  parameter logic [LEN-1:0] SEED   = 25'h1FFFC00,
  parameter logic [LEN-1:0] MASK   = 25'h00FFFFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] data_in,
  input  logic [1:0] addr,
  input  logic       write,
  output logic       sf_on,
  output logic [7:0] sf_star,
  output logic [1:0] sf_layer
);

  localparam logic [LEN-1:0] HV   = LEN'(H * V);
  localparam logic [LEN-1:0] HW   = LEN'(H);
  localparam logic [LEN-1:0] LIM0 = LEN'(H * V - 1);

  function automatic logic [LEN-1:0] seed_of(input int k);
    logic [63:0] m;
    m = 64'(k) * 64'h0A5A5;
    return SEED ^ m[LEN-1:0];
  endfunction

  logic [LEN-1:0] sreg  [LAYERS];
  logic [LEN-1:0] cnt   [LAYERS];
  logic [LEN-1:0] lim   [LAYERS];
  logic [7:0]     spd_s [LAYERS];
  logic [7:0]     spd_a [LAYERS];
  logic [3:0]     timer [LAYERS];

  logic           wrap    [LAYERS];
  logic [4:0]     inc     [LAYERS];
  logic [3:0]     timer_n [LAYERS];
  logic [3:0]     tsum    [LAYERS];
  logic [LEN-1:0] lim_n   [LAYERS];
  logic [LEN-1:0] step    [LAYERS];
  logic           on      [LAYERS];
  logic [7:0]     bright  [LAYERS];

`ifdef PARALLAX_TWINKLE_EN
  logic [7:0] frame;
`endif

  // Per-layer next-state terms.
  // Slow speeds (<8) accumulate in timer and stretch the
  // frame by one line each time the timer overflows 8.
  always_comb begin
    for (int k = 0; k < LAYERS; k++) begin
      wrap[k]    = (cnt[k] == lim[k]);
      tsum[k]    = timer[k] + {1'b0, spd_a[k][2:0]};
      inc[k]     = 5'd0;
      timer_n[k] = timer[k];
      unique case (1'b1)
        (spd_a[k][7:3] != 5'd0): begin
          inc[k]     = spd_a[k][7:3];
          timer_n[k] = timer[k];
        end
        (spd_a[k][7:3] == 5'd0 && tsum[k][3]): begin
          inc[k]     = 5'd1;
          timer_n[k] = tsum[k] - 4'd8;
        end
        default: begin
          inc[k]     = 5'd0;
          timer_n[k] = tsum[k];
        end
      endcase
      lim_n[k]  = HV + (LEN'(inc[k]) * HW) - LEN'(1);
      step[k]   = sreg[k][0] ? ((sreg[k] >> 1) ^ TAPS)
                             : (sreg[k] >> 1);
      on[k]     = &(sreg[k] | MASK);
      bright[k] = sreg[k][7:0] >> k;
    end
  end

  // Priority pick: scan high to low so the lowest on layer
  // is the last assignment and therefore wins.
  logic       win_on;
  logic [7:0] win_star;
  logic [1:0] win_layer;
  logic       win_b8;

  always_comb begin
    win_on    = 1'b0;
    win_star  = 8'd0;
    win_layer = 2'd0;
    win_b8    = 1'b0;
    for (int k = LAYERS - 1; k >= 0; k--) begin
      if (on[k]) begin
        win_on    = 1'b1;
        win_star  = bright[k];
        win_layer = 2'(k);
        win_b8    = sreg[k][8];
      end
    end
  end

  logic [7:0] star_out;

`ifdef PARALLAX_TWINKLE_EN
  always_comb begin
    star_out = win_star;
    if (win_on && (win_b8 == frame[3]))
      star_out = win_star >> 1;
  end
`else
  always_comb begin
    star_out = win_star;
  end

  logic unused_b8;
  assign unused_b8 = win_b8;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LAYERS; k++) begin
        sreg[k]  <= seed_of(k);
        cnt[k]   <= '0;
        lim[k]   <= LIM0;
        spd_s[k] <= 8'd0;
        spd_a[k] <= 8'd0;
        timer[k] <= 4'd0;
      end
      sf_on    <= 1'b0;
      sf_star  <= 8'd0;
      sf_layer <= 2'd0;
`ifdef PARALLAX_TWINKLE_EN
      frame    <= 8'd0;
`endif
    end else begin
      // Writes are taken regardless of en; a write landing on
      // the wrap cycle is seen by spd_a only at the next wrap.
      for (int k = 0; k < LAYERS; k++) begin
        if (write && (addr == 2'(k)))
          spd_s[k] <= data_in;
      end
      if (en) begin
        for (int k = 0; k < LAYERS; k++) begin
          if (wrap[k]) begin
            cnt[k]   <= '0;
            spd_a[k] <= spd_s[k];
            timer[k] <= timer_n[k];
            lim[k]   <= lim_n[k];
          end else begin
            cnt[k] <= cnt[k] + LEN'(1);
          end
          if (cnt[k] == '0)
            sreg[k] <= seed_of(k);
          else
            sreg[k] <= step[k];
        end
        sf_on    <= win_on;
        sf_star  <= star_out;
        sf_layer <= win_layer;
`ifdef PARALLAX_TWINKLE_EN
        if (wrap[0])
          frame <= frame + 8'd1;
`endif
      end
    end
  end

endmodule
